// File: rtl/lvds_tx_word_fifo.sv
// lvds_tx_word_fifo: first-word-fall-through buffer in front of the LVDS link transmit port.
// Each 24-bit user payload is framed as {1'b1, seq[6:0], payload[23:0]} and held until the
// link pulls it through the enq_tx / RDY_enq_tx / EN_enq_tx interface.
module lvds_tx_word_fifo #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              tx_inclock,
    input  logic              reset_n,
    input  logic [23:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              seq_clear,
    output logic [31:0]       enq_tx,
    output logic              RDY_enq_tx,
    input  logic              EN_enq_tx,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned      Depth     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  FullCount = Depth[ADDR_W:0];

    // Word storage; deliberately has no reset.
    logic [31:0]       mem_q [Depth];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [6:0]        seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              not_full;
    logic              not_empty;
    logic              wr_fire;
    logic              pop_fire;
    logic [31:0]       wr_word;

    // Handshake status depends only on registered occupancy; no write-through-pop bypass.
    always_comb begin
        not_full  = (count_q != FullCount);
        not_empty = (count_q != '0);
        // A flush cycle swallows any write or pop that coincides with it.
        wr_fire   = in_valid && not_full && !flush;
        pop_fire  = EN_enq_tx && not_empty && !flush;
        wr_word   = {1'b1, seq_q, in_data};
    end

    // Next-state for pointers, occupancy, sequence tag and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        seq_d       = seq_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            unique case ({wr_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (in_valid && !not_full) begin
                overflow_d = 1'b1;
            end
            if (EN_enq_tx && !not_empty) begin
                underflow_d = 1'b1;
            end
        end

        // The tag only advances on a word that is actually stored; a clear wins over the
        // increment, while the word written this cycle still carries the old tag.
        if (seq_clear) begin
            seq_d = '0;
        end else if (wr_fire) begin
            seq_d = seq_q + 7'd1;
        end
    end

    // Control state with synchronous active-low reset taking priority over everything.
    always_ff @(posedge tx_inclock) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; suppressed while reset is held so reset fully overrides a write.
    always_ff @(posedge tx_inclock) begin
        if (reset_n && wr_fire) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    // FWFT head word; zeroed when empty so stale entries never reach the link with bit 31 set.
    always_comb begin
        in_ready   = not_full;
        RDY_enq_tx = not_empty;
        enq_tx     = not_empty ? mem_q[rd_ptr_q] : 32'h0;
        count      = count_q;
        overflow   = overflow_q;
        underflow  = underflow_q;
    end

endmodule

// File: tb/tb_lvds_tx_word_fifo.sv
// Directed self-checking bench for lvds_tx_word_fifo.
module tb_lvds_tx_word_fifo;

    logic        tx_inclock;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        seq_clear;
    logic [31:0] enq_tx;
    logic        RDY_enq_tx;
    logic        EN_enq_tx;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int checks;
    int errors;

    lvds_tx_word_fifo #(.ADDR_W(3)) dut (
        .tx_inclock (tx_inclock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .seq_clear  (seq_clear),
        .enq_tx     (enq_tx),
        .RDY_enq_tx (RDY_enq_tx),
        .EN_enq_tx  (EN_enq_tx),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial tx_inclock = 1'b0;
    always #5 tx_inclock = ~tx_inclock;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge tx_inclock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        seq_clear = 1'b0;
        EN_enq_tx = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 4'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", count);
        end
        checks++;
        if (in_ready !== 1'b1 || RDY_enq_tx !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: got in_ready=%b rdy=%b want 1/0", in_ready, RDY_enq_tx);
        end
        checks++;
        if (enq_tx !== 32'h0) begin
            errors++; $display("FAIL reset_enq: got %h want 00000000", enq_tx);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0", overflow, underflow);
        end
    endtask

    task automatic test_write_basic();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = 24'(i);
            step();
            if (i == 1) begin
                checks++;
                if (enq_tx !== 32'h80000001 || RDY_enq_tx !== 1'b1) begin
                    errors++; $display("FAIL first_word: got %h rdy=%b want 80000001 rdy=1", enq_tx, RDY_enq_tx);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 4'd3) begin
            errors++; $display("FAIL basic_count: got %0d want 3", count);
        end
    endtask

    task automatic test_pop_paced();
        logic [31:0] exp [3];
        exp[0] = 32'h80000001;
        exp[1] = 32'h81000002;
        exp[2] = 32'h82000003;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (enq_tx !== exp[k]) begin
                errors++; $display("FAIL paced_head%0d: got %h want %h", k, enq_tx, exp[k]);
            end
            EN_enq_tx = 1'b1;
            step();
            EN_enq_tx = 1'b0;
            step(); step(); step();
        end
        checks++;
        if (enq_tx !== 32'h0 || RDY_enq_tx !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL paced_empty: got %h rdy=%b cnt=%0d want 00000000 0 0", enq_tx, RDY_enq_tx, count);
        end
        checks++;
        if (underflow !== 1'b0) begin
            errors++; $display("FAIL paced_underflow: got %b want 0", underflow);
        end
    endtask

    // Tags continue from 3 after the basic test.
    task automatic test_full();
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h100 + 24'(i);
            step();
        end
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_state: got cnt=%0d in_ready=%b want 8 0", count, in_ready);
        end
        in_data = 24'hABCDEF;
        step();
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++; $display("FAIL full_overflow: got ovf=%b cnt=%0d want 1 8", overflow, count);
        end
        EN_enq_tx = 1'b1;
        step();
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd7) begin
            errors++; $display("FAIL full_pop_write: got cnt=%0d want 7", count);
        end
        // Back-to-back drain; the dropped ABCDEF word must never appear.
        for (int i = 1; i < 8; i++) begin
            exp = {1'b1, 7'(3 + i), 24'h100 + 24'(i)};
            checks++;
            if (enq_tx !== exp) begin
                errors++; $display("FAIL drain%0d: got %h want %h", i, enq_tx, exp);
            end
            EN_enq_tx = 1'b1;
            step();
        end
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd0 || RDY_enq_tx !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got cnt=%0d rdy=%b want 0 0", count, RDY_enq_tx);
        end
    endtask

    task automatic test_seq_wrap();
        logic [31:0] exp;
        do_reset();
        for (int j = 0; j < 130; j++) begin
            in_valid = 1'b1;
            in_data  = 24'(j);
            step();
            in_valid = 1'b0;
            exp = {1'b1, 7'(j % 128), 24'(j)};
            checks++;
            if (enq_tx !== exp) begin
                errors++; $display("FAIL wrap%0d: got %h want %h", j, enq_tx, exp);
            end
            EN_enq_tx = 1'b1;
            step();
            EN_enq_tx = 1'b0;
        end
        seq_clear = 1'b1;
        step();
        seq_clear = 1'b0;
        in_valid  = 1'b1;
        in_data   = 24'h55;
        step();
        // seq is now 1; clear coinciding with a write keeps the old tag on that word.
        in_data   = 24'h66;
        seq_clear = 1'b1;
        step();
        seq_clear = 1'b0;
        in_data   = 24'h77;
        step();
        in_valid = 1'b0;
        checks++;
        if (enq_tx !== 32'h80000055) begin
            errors++; $display("FAIL seqclr_head: got %h want 80000055", enq_tx);
        end
        EN_enq_tx = 1'b1;
        step();
        checks++;
        if (enq_tx !== 32'h81000066) begin
            errors++; $display("FAIL seqclr_same_cycle: got %h want 81000066", enq_tx);
        end
        step();
        checks++;
        if (enq_tx !== 32'h80000077) begin
            errors++; $display("FAIL seqclr_after: got %h want 80000077", enq_tx);
        end
        step();
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd0 || underflow !== 1'b0) begin
            errors++; $display("FAIL seqclr_drain: got cnt=%0d unf=%b want 0 0", count, underflow);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h200 + 24'(i);
            step();
        end
        in_data   = 24'h999;
        flush     = 1'b1;
        EN_enq_tx = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd0 || RDY_enq_tx !== 1'b0 || enq_tx !== 32'h0) begin
            errors++; $display("FAIL flush_state: got cnt=%0d rdy=%b enq=%h want 0 0 00000000", count, RDY_enq_tx, enq_tx);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
        in_valid = 1'b1;
        in_data  = 24'hAAA;
        step();
        in_valid = 1'b0;
        checks++;
        if (enq_tx !== 32'h85000AAA || count !== 4'd1) begin
            errors++; $display("FAIL flush_tag: got %h cnt=%0d want 85000AAA 1", enq_tx, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // Empty FIFO: write accepted, coincident pop rejected and flagged.
        in_valid  = 1'b1;
        in_data   = 24'h300;
        EN_enq_tx = 1'b1;
        step();
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || enq_tx !== 32'h80000300) begin
            errors++; $display("FAIL empty_wr_pop: got cnt=%0d unf=%b enq=%h want 1 1 80000300", count, underflow, enq_tx);
        end
        for (int i = 1; i < 4; i++) begin
            in_data = 24'h300 + 24'(i);
            step();
        end
        checks++;
        if (count !== 4'd4) begin
            errors++; $display("FAIL mid_prefill: got cnt=%0d want 4", count);
        end
        in_data   = 24'h3FF;
        EN_enq_tx = 1'b1;
        reset_n   = 1'b0;
        step();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        EN_enq_tx = 1'b0;
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1 || RDY_enq_tx !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state: got cnt=%0d in_ready=%b rdy=%b want 0 1 0", count, in_ready, RDY_enq_tx);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
        end
        in_valid = 1'b1;
        in_data  = 24'h123;
        step();
        in_valid = 1'b0;
        checks++;
        if (enq_tx !== 32'h80000123) begin
            errors++; $display("FAIL post_reset_tag: got %h want 80000123", enq_tx);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        seq_clear = 1'b0;
        EN_enq_tx = 1'b0;
        test_reset();
        test_write_basic();
        test_pop_paced();
        test_full();
        test_seq_wrap();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
